// File: rtl/part_select_unpacker.sv
// Streams a captured word out as FIELD_W-bit fields, walking downward from a
// starting MSB index as word[idx -: FIELD_W], over a valid/ready handshake.
module part_select_unpacker #(
    parameter int DATA_W  = 32,
    parameter int FIELD_W = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    input  logic [$clog2(DATA_W)-1:0]          in_base,
    input  logic [$clog2(DATA_W/FIELD_W):0]    in_count,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FIELD_W-1:0]                 out_field,
    output logic signed [$clog2(DATA_W):0]     out_index,
    output logic                               out_last,
    output logic                               busy
);

    localparam int MAX_F  = DATA_W / FIELD_W;
    localparam int BASE_W = $clog2(DATA_W);
    localparam int CNT_W  = $clog2(MAX_F) + 1;
    localparam int IDX_W  = BASE_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } stateT;

    // Bits below position 0 read as zero: a negative index yields an all-zero field,
    // otherwise the zero padding under the word supplies the missing low bits.
    function automatic logic [FIELD_W-1:0] extractField(
        input logic [DATA_W-1:0]       word,
        input logic signed [IDX_W-1:0] idx
    );
        logic [DATA_W+FIELD_W-1:0] padded;
        logic [IDX_W-1:0]          shamt;
        logic [FIELD_W-1:0]        field;
        padded = {word, {FIELD_W{1'b0}}};
        shamt  = {1'b0, idx[BASE_W-1:0]} + IDX_W'(1);
        field  = FIELD_W'(padded >> shamt);
        if (idx[IDX_W-1]) begin
            field = '0;
        end
        return field;
    endfunction

    stateT                    r_state;
    stateT                    w_nextState;
    logic [DATA_W-1:0]        r_word;
    logic [DATA_W-1:0]        w_nextWord;
    logic signed [IDX_W-1:0]  r_idx;
    logic signed [IDX_W-1:0]  w_nextIdx;
    logic [CNT_W-1:0]         r_rem;
    logic [CNT_W-1:0]         w_nextRem;
    logic                     r_valid;
    logic                     w_nextValid;
    logic [FIELD_W-1:0]       r_field;
    logic [FIELD_W-1:0]       w_nextField;
    logic signed [IDX_W-1:0]  r_index;
    logic signed [IDX_W-1:0]  w_nextIndex;
    logic                     r_last;
    logic                     w_nextLast;

    logic [CNT_W-1:0]         w_effCount;
    logic signed [IDX_W-1:0]  w_baseIdx;
    logic signed [IDX_W-1:0]  w_stepIdx;
    logic [CNT_W-1:0]         w_stepRem;

    assign w_effCount = (in_count > CNT_W'(MAX_F)) ? CNT_W'(MAX_F) : in_count;
    assign w_baseIdx  = $signed({1'b0, in_base});
    assign w_stepIdx  = r_idx - $signed(IDX_W'(FIELD_W));
    assign w_stepRem  = r_rem - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
            r_field <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_word  <= w_nextWord;
            r_idx   <= w_nextIdx;
            r_rem   <= w_nextRem;
            r_valid <= w_nextValid;
            r_field <= w_nextField;
            r_index <= w_nextIndex;
            r_last  <= w_nextLast;
        end
    end

    // Outputs are computed one cycle ahead so every out_* comes straight from a flop.
    always_comb begin
        w_nextState = r_state;
        w_nextWord  = r_word;
        w_nextIdx   = r_idx;
        w_nextRem   = r_rem;
        w_nextValid = r_valid;
        w_nextField = r_field;
        w_nextIndex = r_index;
        w_nextLast  = r_last;
        case (r_state)
            IDLE: begin
                if (in_valid && (w_effCount != '0)) begin
                    w_nextState = EMIT;
                    w_nextWord  = in_data;
                    w_nextIdx   = w_baseIdx;
                    w_nextRem   = w_effCount;
                    w_nextValid = 1'b1;
                    w_nextField = extractField(in_data, w_baseIdx);
                    w_nextIndex = w_baseIdx;
                    w_nextLast  = (w_effCount == CNT_W'(1));
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_nextIdx = w_stepIdx;
                    w_nextRem = w_stepRem;
                    if (r_last) begin
                        w_nextState = IDLE;
                        w_nextValid = 1'b0;
                        w_nextField = '0;
                        w_nextIndex = '0;
                        w_nextLast  = 1'b0;
                    end else begin
                        w_nextField = extractField(r_word, w_stepIdx);
                        w_nextIndex = w_stepIdx;
                        w_nextLast  = (w_stepRem == CNT_W'(1));
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextValid = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign busy      = (r_state == EMIT);
    assign out_valid = r_valid;
    assign out_field = r_field;
    assign out_index = r_index;
    assign out_last  = r_last;

endmodule

// File: tb/tb_part_select_unpacker.sv
// Self-checking bench for part_select_unpacker: directed scenarios plus random
// words, checked against a queue-based field model built from plain arithmetic.
module tb_part_select_unpacker;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic [4:0]        in_base = '0;
    logic [4:0]        in_count = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_field;
    logic signed [5:0] out_index;
    logic              out_last;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int field;
        int index;
        bit last;
    } fieldT;

    fieldT       expQ[$];
    logic [31:0] pendData[$];
    int          pendBase[$];
    int          pendCount[$];

    always #5 clk = ~clk;

    part_select_unpacker #(.DATA_W(32), .FIELD_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_base   (in_base),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the word is viewed with two zero bits appended below bit 0, so the
    // field whose MSB sits at idx is two bits taken from that extended value.
    task automatic pushModel(input logic [31:0] data, input int base, input int count);
        int          eff;
        int          idx;
        logic [33:0] ext;
        logic [33:0] sh;
        fieldT       f;
        eff = (count > 16) ? 16 : count;
        ext = {data, 2'b00};
        for (int k = 0; k < eff; k++) begin
            idx = base - 2 * k;
            if (idx < -1) begin
                f.field = 0;
            end else begin
                sh = ext >> (idx + 1);
                f.field = int'(sh[1:0]);
            end
            f.index = idx;
            f.last = (k == eff - 1);
            expQ.push_back(f);
        end
    endtask

    task automatic addWord(input logic [31:0] data, input int base, input int count);
        pendData.push_back(data);
        pendBase.push_back(base);
        pendCount.push_back(count);
    endtask

    task automatic checkFront();
        bit emitting;
        emitting = (expQ.size() != 0);
        checkOutput("in_ready", in_ready, !emitting);
        checkOutput("busy", busy, emitting);
        checkOutput("out_valid", out_valid, emitting);
        if (emitting) begin
            checkOutput("out_field", out_field, expQ[0].field);
            checkOutput("out_index", out_index, expQ[0].index);
            checkOutput("out_last", out_last, expQ[0].last);
        end
    endtask

    // readyMode: 0 = always ready, 1 = random, 2 = stall 3 cycles on the 2nd field.
    task automatic applyStimulus(input int readyMode, input bit holdValid);
        int cycles;
        int popped;
        int stallCnt;
        bit accept;
        cycles = 0;
        popped = 0;
        stallCnt = 0;
        while ((pendData.size() != 0 || expQ.size() != 0) && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            checkFront();
            accept = 1'b0;
            in_valid = 1'b0;
            in_data = $urandom;
            in_base = 5'($urandom);
            in_count = 5'($urandom);
            if (pendData.size() != 0 && (holdValid || expQ.size() == 0)) begin
                if (readyMode != 1 || holdValid || $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data = pendData[0];
                    in_base = 5'(pendBase[0]);
                    in_count = 5'(pendCount[0]);
                    accept = (expQ.size() == 0);
                end
            end
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (expQ.size() != 0 && popped == 1 && stallCnt < 3) begin
                        out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (expQ.size() != 0 && out_ready) begin
                void'(expQ.pop_front());
                popped++;
            end
            if (accept) begin
                pushModel(pendData[0], pendBase[0], pendCount[0]);
                void'(pendData.pop_front());
                void'(pendBase.pop_front());
                void'(pendCount.pop_front());
            end
        end
        checkOutput("cycle_budget", cycles < 2000, 1);
        @(negedge clk);
        checkFront();
        in_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] starting part_select_unpacker bench");

        // Reset state, then in_ready must rise once rst drops.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_field", out_field, 0);
        checkOutput("rst_out_index", out_index, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        checkFront();

        $display("[TB] basic word");
        addWord(32'hA5A5_1234, 31, 4);
        applyStimulus(0, 1'b0);

        $display("[TB] low boundary");
        addWord(32'h0000_0001, 0, 2);
        applyStimulus(0, 1'b0);

        $display("[TB] backpressure on second field");
        addWord(32'hA5A5_1234, 31, 4);
        applyStimulus(2, 1'b0);

        $display("[TB] zero count");
        addWord(32'hDEAD_BEEF, 17, 0);
        applyStimulus(0, 1'b0);

        $display("[TB] saturated count");
        addWord(32'hFFFF_FFFF, 31, 31);
        applyStimulus(0, 1'b0);

        $display("[TB] reset mid-stream");
        @(negedge clk);
        checkFront();
        in_valid = 1'b1;
        in_data = 32'hA5A5_1234;
        in_base = 5'd31;
        in_count = 5'd4;
        out_ready = 1'b1;
        pushModel(32'hA5A5_1234, 31, 4);
        @(negedge clk);
        in_valid = 1'b0;
        checkFront();
        void'(expQ.pop_front());
        @(negedge clk);
        checkFront();
        rst = 1'b1;
        @(negedge clk);
        expQ.delete();
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_last", out_last, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkFront();
        end

        $display("[TB] back-to-back words");
        addWord(32'h9C3A_5F01, 31, 2);
        addWord(32'h4000_0003, 1, 2);
        applyStimulus(0, 1'b1);

        $display("[TB] random words");
        for (int batch = 0; batch < 5; batch++) begin
            for (int w = 0; w < 8; w++) begin
                addWord($urandom, $urandom_range(0, 31), $urandom_range(0, 31));
            end
            applyStimulus(1, (batch % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
